// File: rtl/instr_imm_encoder.sv
// RV32I instruction encoder: scatters field-level requests (opcode, regs, funct, immediate)
// into instruction words, flags unrepresentable immediates and streams words with addresses.
module instr_imm_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ERR_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  input  logic             addr_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_addr,
  output logic             out_err,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
  localparam logic signed [31:0] IMM12_MAX = 32'sd2047;
  localparam logic signed [31:0] IMMB_MIN  = -32'sd4096;
  localparam logic signed [31:0] IMMB_MAX  = 32'sd4094;
  localparam logic signed [31:0] IMMJ_MIN  = -32'sd1048576;
  localparam logic signed [31:0] IMMJ_MAX  = 32'sd1048574;

  function automatic logic in_range(input logic signed [31:0] v,
                                    input logic signed [31:0] lo,
                                    input logic signed [31:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Returns {err, instr}; on error the word is still packed from the truncated fields.
  function automatic logic [32:0] encode(input logic [6:0]  op,
                                         input logic [4:0]  rd,
                                         input logic [4:0]  rs1,
                                         input logic [4:0]  rs2,
                                         input logic [2:0]  f3,
                                         input logic [6:0]  f7,
                                         input logic [31:0] imm);
    logic [31:0]        w;
    logic               e;
    logic signed [31:0] s;
    s = signed'(imm);
    w = {f7, rs2, rs1, f3, rd, op};
    e = 1'b0;
    case (op)
      OP_R: e = 1'b0;
      OP_IMM, OP_LOAD, OP_JALR: begin
        if ((op == OP_IMM) && ((f3 == 3'b001) || (f3 == 3'b101))) begin
          w = {f7, imm[4:0], rs1, f3, rd, op};
          e = |imm[31:5];
        end else begin
          w = {imm[11:0], rs1, f3, rd, op};
          e = !in_range(s, IMM12_MIN, IMM12_MAX);
        end
      end
      OP_STORE: begin
        w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        e = !in_range(s, IMM12_MIN, IMM12_MAX);
      end
      OP_BRANCH: begin
        w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        e = imm[0] || !in_range(s, IMMB_MIN, IMMB_MAX);
      end
      OP_LUI, OP_AUIPC: begin
        w = {imm[31:12], rd, op};
        e = |imm[11:0];
      end
      OP_JAL: begin
        w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        e = imm[0] || !in_range(s, IMMJ_MIN, IMMJ_MAX);
      end
      default: e = 1'b1;
    endcase
    return {e, w};
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic              r_vld_p1;
  logic [6:0]        r_op_p1;
  logic [4:0]        r_rd_p1;
  logic [4:0]        r_rs1_p1;
  logic [4:0]        r_rs2_p1;
  logic [2:0]        r_f3_p1;
  logic [6:0]        r_f7_p1;
  logic [31:0]       r_imm_p1;
  logic              r_vld_p2;
  logic [31:0]       r_instr_p2;
  logic              r_err_p2;
  logic [31:0]       r_addr;
  logic              r_clr_pend;
  logic [ERR_W-1:0]  r_err_cnt;

  logic              w_s2_adv;
  logic              w_s1_adv;
  logic              w_out_hs;
  logic [32:0]       w_enc_p1;

  assign w_s2_adv = !r_vld_p2 || out_ready;
  assign w_s1_adv = !r_vld_p1 || w_s2_adv;
  assign w_out_hs = r_vld_p2 && out_ready;
  assign w_enc_p1 = encode(r_op_p1, r_rd_p1, r_rs1_p1, r_rs2_p1, r_f3_p1, r_f7_p1, r_imm_p1);

  assign in_ready  = w_s1_adv;
  assign out_valid = r_vld_p2;
  assign out_instr = r_instr_p2;
  assign out_err   = r_err_p2;
  assign out_addr  = r_addr;
  assign err_count = r_err_cnt;

  // Stage 1: raw request capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
    end else if (w_s1_adv) begin
      r_vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && w_s1_adv) begin
      r_op_p1  <= in_opcode;
      r_rd_p1  <= in_rd;
      r_rs1_p1 <= in_rs1;
      r_rs2_p1 <= in_rs2;
      r_f3_p1  <= in_funct3;
      r_f7_p1  <= in_funct7;
      r_imm_p1 <= in_imm;
    end
  end

  // Stage 2: encoded word, error flag, address and error count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2   <= 1'b0;
      r_instr_p2 <= 32'h0;
      r_err_p2   <= 1'b0;
    end else if (w_s2_adv) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_instr_p2 <= w_enc_p1[31:0];
        r_err_p2   <= w_enc_p1[32];
      end
    end
  end

  // A clear seen while a word is stalled is remembered so that word keeps its address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= BASE_ADDR;
      r_clr_pend <= 1'b0;
    end else if (w_out_hs) begin
      r_addr     <= (addr_clr || r_clr_pend) ? BASE_ADDR : r_addr + 32'd4;
      r_clr_pend <= 1'b0;
    end else if (addr_clr) begin
      if (r_vld_p2) begin
        r_clr_pend <= 1'b1;
      end else begin
        r_addr <= BASE_ADDR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (w_out_hs && r_err_p2) begin
      r_err_cnt <= sat_inc(r_err_cnt);
    end
  end

endmodule

// File: tb/tb_instr_imm_encoder.sv
// Directed bench for instr_imm_encoder: vector table for the encodings plus hand-written
// sequences for back-pressure, address clear, error saturation and mid-stream reset.
module tb_instr_imm_encoder;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          EW   = 4;
  localparam int          NV   = 19;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [6:0]    in_opcode;
  logic [4:0]    in_rd;
  logic [4:0]    in_rs1;
  logic [4:0]    in_rs2;
  logic [2:0]    in_funct3;
  logic [6:0]    in_funct7;
  logic [31:0]   in_imm;
  logic          addr_clr;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [31:0]   out_addr;
  logic          out_err;
  logic [EW-1:0] err_count;

  instr_imm_encoder #(.BASE_ADDR(BASE), .ERR_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .addr_clr(addr_clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
    .err_count(err_count)
  );

  typedef struct packed {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  vec_t vecs [NV];
  int   n_checks = 0;
  int   n_err    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_opcode = v.op;
    in_rd     = v.rd;
    in_rs1    = v.rs1;
    in_rs2    = v.rs2;
    in_funct3 = v.f3;
    in_funct7 = v.f7;
    in_imm    = v.imm;
    in_valid  = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Single request with out_ready high; checks latency, word, error and address.
  task automatic send_vec(input vec_t v, input logic [31:0] exp_addr, input string nm);
    int k;
    @(negedge clk);
    drive(v);
    chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 5) begin
      @(negedge clk);
      k++;
    end
    chk({nm, " latency"}, 32'(k), 32'd2);
    chk({nm, " instr"}, out_instr, v.instr);
    chk({nm, " err"}, 32'(out_err), 32'(v.err));
    chk({nm, " addr"}, out_addr, exp_addr);
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t addi(input logic [31:0] imm);
    addi = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, imm, {imm[11:0], 20'h00093}, 1'b0};
  endfunction

  initial begin
    vec_t w [4];
    vec_t ev;
    logic [31:0] aexp [4];
    int k;

    vecs[0]  = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0};
    vecs[1]  = '{7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'h0000_0008, 32'h0020_A423, 1'b0};
    vecs[2]  = '{7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'h0000_0800, 32'h8020_A023, 1'b1};
    vecs[3]  = '{7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0};
    vecs[4]  = '{7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0003, 32'h0000_0163, 1'b1};
    vecs[5]  = '{7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000, 32'h1234_52B7, 1'b0};
    vecs[6]  = '{7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5001, 32'h1234_52B7, 1'b1};
    vecs[7]  = '{7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0010_0000, 32'h8000_00EF, 1'b1};
    vecs[8]  = '{7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFF0_0000, 32'h8000_00EF, 1'b0};
    vecs[9]  = '{7'h13, 5'd1, 5'd1, 5'd0, 3'd1, 7'h00, 32'h0000_0020, 32'h0000_9093, 1'b1};
    vecs[10] = '{7'h13, 5'd1, 5'd1, 5'd0, 3'd1, 7'h00, 32'h0000_0003, 32'h0030_9093, 1'b0};
    vecs[11] = '{7'h13, 5'd1, 5'd1, 5'd0, 3'd5, 7'h20, 32'h0000_0005, 32'h4050_D093, 1'b0};
    vecs[12] = '{7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0000_0000, 32'h0020_81B3, 1'b0};
    vecs[13] = '{7'h7F, 5'd1, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0000_0000, 32'h0020_80FF, 1'b1};
    vecs[14] = '{7'h03, 5'd1, 5'd2, 5'd0, 3'd2, 7'h00, 32'h0000_07FF, 32'h7FF1_2083, 1'b0};
    vecs[15] = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F7FF, 32'h7FF0_0093, 1'b1};
    vecs[16] = '{7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0002, 32'h0020_006F, 1'b0};
    vecs[17] = '{7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0FFE, 32'h7E00_0FE3, 1'b0};
    vecs[18] = '{7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_1000, 32'h8000_0063, 1'b1};

    in_valid = 1'b0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0; addr_clr = 1'b0; out_ready = 1'b1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_instr", out_instr, 32'h0);
    chk("reset out_err", 32'(out_err), 32'd0);
    chk("reset err_count", 32'(err_count), 32'd0);
    chk("reset out_addr", out_addr, BASE);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++)
      send_vec(vecs[i], BASE + 32'(4 * i), $sformatf("v%0d", i));
    chk("err_count after table", 32'(err_count), 32'd8);

    // 9 more error words drive the 4-bit counter past 15: it must stick at 15
    for (int j = 0; j < 9; j++)
      send_vec(vecs[13], BASE + 32'(4 * (NV + j)), $sformatf("sat%0d", j));
    chk("err_count saturated", 32'(err_count), 32'hF);

    // Back-pressure: out_ready low while 4 words stream in
    do_reset();
    chk("err_count after reset", 32'(err_count), 32'd0);
    for (int i = 0; i < 4; i++) w[i] = addi(32'(i + 1));
    out_ready = 1'b0;
    @(negedge clk); drive(w[0]); @(posedge clk);
    @(negedge clk); drive(w[1]);
    chk("bp in_ready s2 empty", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk); drive(w[2]);
    chk("bp in_ready full", 32'(in_ready), 32'd0);
    chk("bp out_valid", 32'(out_valid), 32'd1);
    chk("bp hold instr", out_instr, w[0].instr);
    chk("bp hold addr", out_addr, BASE);
    for (int h = 0; h < 2; h++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("bp hold%0d in_ready", h), 32'(in_ready), 32'd0);
      chk($sformatf("bp hold%0d instr", h), out_instr, w[0].instr);
      chk($sformatf("bp hold%0d addr", h), out_addr, BASE);
    end
    out_ready = 1'b1;
    #1 chk("bp in_ready released", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk); drive(w[3]);
    chk("bp w1 instr", out_instr, w[1].instr);
    chk("bp w1 addr", out_addr, BASE + 32'd4);
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    chk("bp w2 instr", out_instr, w[2].instr);
    chk("bp w2 addr", out_addr, BASE + 32'd8);
    @(posedge clk);
    @(negedge clk);
    chk("bp w3 valid", 32'(out_valid), 32'd1);
    chk("bp w3 instr", out_instr, w[3].instr);
    chk("bp w3 addr", out_addr, BASE + 32'd12);
    @(posedge clk);
    @(negedge clk);
    chk("bp drained", 32'(out_valid), 32'd0);

    // addr_clr during the handshake of the word at BASE+8
    do_reset();
    for (int i = 0; i < 4; i++) w[i] = addi(32'(16 + i));
    aexp[0] = BASE; aexp[1] = BASE + 32'd4; aexp[2] = BASE + 32'd8; aexp[3] = BASE;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      addr_clr = 1'b0;
      if (c < 4) drive(w[c]);
      else in_valid = 1'b0;
      if (out_valid && k < 4) begin
        chk($sformatf("clr w%0d instr", k), out_instr, w[k].instr);
        chk($sformatf("clr w%0d addr", k), out_addr, aexp[k]);
        addr_clr = (k == 2);
        k++;
      end
      @(posedge clk);
    end
    @(negedge clk);
    addr_clr = 1'b0;
    chk("clr word count", 32'(k), 32'd4);

    // Reset with both stages full: nothing may come out afterwards
    ev = vecs[13];
    out_ready = 1'b0;
    @(negedge clk); drive(ev); @(posedge clk);
    @(negedge clk); drive(ev); @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    chk("midrst pre valid", 32'(out_valid), 32'd1);
    chk("midrst pre err", 32'(out_err), 32'd1);
    chk("midrst pre in_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst out_addr", out_addr, BASE);
    chk("midrst out_instr", out_instr, 32'h0);
    chk("midrst out_err", 32'(out_err), 32'd0);
    chk("midrst err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("midrst flushed%0d", c), 32'(out_valid), 32'd0);
    end
    chk("midrst err_count after", 32'(err_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
